// File: rtl/gfx_cmd_pkg.sv
// gfx_cmd_pkg: opcodes, sequence lengths and FSM states for the graphics command transmitter
package gfx_cmd_pkg;
  localparam logic [7:0] OP_POINT  = 8'h50;
  localparam logic [7:0] OP_LINE   = 8'h4C;
  localparam int         POINT_LEN = 4;
  localparam int         LINE_LEN  = 13;
  localparam int         LINE_FILL = 5;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_ERR} state_t;
endpackage

// File: rtl/gfx_cmd_tx_if.sv
// gfx_cmd_tx_if: request handshake and CCU byte stream of the command transmitter
interface gfx_cmd_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [7:0] x0;
  logic [7:0] y0;
  logic [7:0] x1;
  logic [7:0] y1;
  logic [7:0] colour;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       req_err;
  logic       busy;
  modport master (
    output req_valid, req_op, x0, y0, x1, y1, colour,
    input  req_ready, cmd, cmd_valid, req_err, busy
  );
  modport slave (
    input  req_valid, req_op, x0, y0, x1, y1, colour,
    output req_ready, cmd, cmd_valid, req_err, busy
  );
endinterface

// File: rtl/gfx_cmd_tx_line_normalizer.sv
// line_normalizer: orders line endpoints by x and flags octants the CCU line loop supports
module line_normalizer (
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  output logic [7:0] xs,
  output logic [7:0] ys,
  output logic [7:0] xe,
  output logic [7:0] ye,
  output logic       ok
);
  logic              swap;
  logic signed [8:0] dx;
  logic signed [8:0] dy;
  always_comb begin
    swap = x1 < x0;
    xs   = swap ? x1 : x0;
    ys   = swap ? y1 : y0;
    xe   = swap ? x0 : x1;
    ye   = swap ? y0 : y1;
    dx   = $signed({1'b0, xe}) - $signed({1'b0, xs});
    dy   = $signed({1'b0, ye}) - $signed({1'b0, ys});
    ok   = !dy[8] && (dy <= dx);
  end
endmodule

// File: rtl/gfx_cmd_tx.sv
// gfx_cmd_tx: serialises point/line requests into the CCU cmd byte stream with a post-command gap
module gfx_cmd_tx
  import gfx_cmd_pkg::*;
#(
  parameter int         GAP_CYCLES = 16,
  parameter logic [7:0] FILL_BYTE  = 8'h00
) (
  input logic         clk,
  input logic         rst_n,
  gfx_cmd_tx_if.slave bus
);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] gap_q, gap_d;
  logic       op_q, op_d;
  logic [7:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, col_q, col_d;
  logic [7:0] n_xs, n_ys, n_xe, n_ye;
  logic       n_ok;
  logic [3:0] last;
  logic [7:0] byte_v;

  line_normalizer u_norm (
    .x0(bus.x0), .y0(bus.y0), .x1(bus.x1), .y1(bus.y1),
    .xs(n_xs), .ys(n_ys), .xe(n_xe), .ye(n_ye), .ok(n_ok)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    col_d   = col_q;
    last    = op_q ? 4'(LINE_LEN - 1) : 4'(POINT_LEN - 1);
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        op_d    = bus.req_op;
        a_d     = bus.req_op ? n_xs : bus.x0;
        b_d     = bus.req_op ? n_ys : bus.y0;
        c_d     = n_xe;
        d_d     = n_ye;
        col_d   = bus.colour;
        cnt_d   = 4'd0;
        state_d = (bus.req_op && !n_ok) ? S_ERR : S_SEND;
      end
      S_SEND: begin
        cnt_d   = cnt_q + 4'd1;
        gap_d   = 8'(GAP_CYCLES);
        state_d = (cnt_q != last) ? S_SEND : (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        gap_d   = gap_q - 8'd1;
        state_d = (gap_q <= 8'd1) ? S_IDLE : S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line tail repeats the start point so the CCU can reseed its loop after the filler bytes
  always_comb begin
    byte_v = FILL_BYTE;
    if (op_q)
      case (cnt_q)
        4'd0:        byte_v = OP_LINE;
        4'd1, 4'd11: byte_v = a_q;
        4'd2, 4'd12: byte_v = b_q;
        4'd3:        byte_v = c_q;
        4'd4:        byte_v = d_q;
        4'd5:        byte_v = col_q;
        default:     byte_v = FILL_BYTE;
      endcase
    else
      case (cnt_q)
        4'd0:    byte_v = OP_POINT;
        4'd1:    byte_v = a_q;
        4'd2:    byte_v = b_q;
        4'd3:    byte_v = col_q;
        default: byte_v = FILL_BYTE;
      endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      col_q   <= col_d;
    end

  assign bus.req_ready = state_q == S_IDLE;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.req_err   = state_q == S_ERR;
  assign bus.cmd_valid = state_q == S_SEND;
  assign bus.cmd       = (state_q == S_SEND) ? byte_v : FILL_BYTE;
endmodule

// File: tb/tb_gfx_cmd_tx.sv
// tb_gfx_cmd_tx: directed and random requests checked against a byte-queue model of the command stream
module tb_gfx_cmd_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passes = 0;
  int   total = 0;
  always #5 clk = ~clk;

  gfx_cmd_tx_if ia ();
  gfx_cmd_tx_if ib ();

  gfx_cmd_tx #(.GAP_CYCLES(16), .FILL_BYTE(8'h00)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  gfx_cmd_tx #(.GAP_CYCLES(0),  .FILL_BYTE(8'hA5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: expected byte list of a request, empty with rej=1 when the line is refused
  task automatic model(input logic op, input int x0, input int y0, input int x1, input int y1,
                       input int col, output logic [7:0] q[$], output logic rej);
    int xs, ys, xe, ye;
    q = {};
    rej = 1'b0;
    if (!op) begin
      q = '{8'h50, 8'(x0), 8'(y0), 8'(col)};
      return;
    end
    if (x1 < x0) begin xs = x1; ys = y1; xe = x0; ye = y0; end
    else begin xs = x0; ys = y0; xe = x1; ye = y1; end
    if (ye - ys < 0 || ye - ys > xe - xs) begin
      rej = 1'b1;
      return;
    end
    q = '{8'h4C, 8'(xs), 8'(ys), 8'(xe), 8'(ye), 8'(col)};
    for (int i = 0; i < 5; i++) q.push_back(8'h00);
    q.push_back(8'(xs));
    q.push_back(8'(ys));
  endtask

  task automatic drive_a(input logic op, input int x0, input int y0, input int x1, input int y1, input int col);
    int n = 0;
    while (!ia.req_ready && n < 100) begin tick(); n++; end
    chk("ready_before_req", 8'(ia.req_ready), 8'd1);
    ia.req_op = op; ia.x0 = 8'(x0); ia.y0 = 8'(y0); ia.x1 = 8'(x1); ia.y1 = 8'(y1); ia.colour = 8'(col);
    ia.req_valid = 1'b1;
    tick();
    ia.req_valid = 1'b0;
    ia.x0 = 8'hFF; ia.y0 = 8'hFF; ia.x1 = 8'hFF; ia.y1 = 8'hFF; ia.colour = 8'hFF;
  endtask

  task automatic run_a(input logic op, input int x0, input int y0, input int x1, input int y1, input int col);
    logic [7:0] q[$];
    logic rej;
    model(op, x0, y0, x1, y1, col, q, rej);
    drive_a(op, x0, y0, x1, y1, col);
    if (rej) begin
      chk("err_pulse", 8'(ia.req_err), 8'd1);
      chk("err_cmd_valid", 8'(ia.cmd_valid), 8'd0);
      chk("err_busy", 8'(ia.busy), 8'd1);
      chk("err_ready_low", 8'(ia.req_ready), 8'd0);
      tick();
      chk("err_clear", 8'(ia.req_err), 8'd0);
      chk("err_ready_back", 8'(ia.req_ready), 8'd1);
      return;
    end
    foreach (q[i]) begin
      chk($sformatf("byte%0d", i), ia.cmd, q[i]);
      chk("cmd_valid_send", 8'(ia.cmd_valid), 8'd1);
      chk("ready_send", 8'(ia.req_ready), 8'd0);
      tick();
    end
    for (int g = 0; g < 16; g++) begin
      chk("gap_valid", 8'(ia.cmd_valid), 8'd0);
      chk("gap_cmd", ia.cmd, 8'h00);
      chk("gap_busy", 8'(ia.busy), 8'd1);
      chk("gap_ready", 8'(ia.req_ready), 8'd0);
      tick();
    end
    chk("ready_after_gap", 8'(ia.req_ready), 8'd1);
    chk("idle_busy", 8'(ia.busy), 8'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic rej;
    ia.req_valid = 0; ia.req_op = 0; ia.x0 = 0; ia.y0 = 0; ia.x1 = 0; ia.y1 = 0; ia.colour = 0;
    ib.req_valid = 0; ib.req_op = 0; ib.x0 = 0; ib.y0 = 0; ib.x1 = 0; ib.y1 = 0; ib.colour = 0;
    #12;
    chk("rst_cmd", ia.cmd, 8'h00);
    chk("rst_cmd_valid", 8'(ia.cmd_valid), 8'd0);
    chk("rst_ready", 8'(ia.req_ready), 8'd1);
    chk("rst_err", 8'(ia.req_err), 8'd0);
    chk("rst_busy", 8'(ia.busy), 8'd0);
    chk("rst_cmd_b", ib.cmd, 8'hA5);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_a(1'b0, 10, 20, 0, 0, 7);
    run_a(1'b1, 0, 0, 8, 3, 5);
    run_a(1'b1, 8, 3, 0, 0, 5);
    run_a(1'b1, 0, 0, 3, 8, 9);
    run_a(1'b1, 0, 5, 8, 0, 9);
    run_a(1'b1, 4, 4, 4, 4, 1);
    run_a(1'b1, 0, 0, 255, 255, 2);
    run_a(1'b1, 255, 0, 0, 255, 3);

    for (int r = 0; r < 30; r++) begin
      int x0, y0, x1, y1;
      x0 = int'($urandom_range(255)); y0 = int'($urandom_range(255));
      x1 = int'($urandom_range(255)); y1 = int'($urandom_range(255));
      if (r % 2 == 0) begin
        x1 = int'($urandom_range(255, x0));
        y1 = y0 + int'($urandom_range(x1 - x0));
        if (y1 > 255) y1 = 255;
      end
      run_a(1'($urandom_range(1)), x0, y0, x1, y1, int'($urandom_range(255)));
    end

    // Back-to-back on the zero-gap instance with req_valid held high
    ib.req_op = 0; ib.x0 = 8'h11; ib.y0 = 8'h22; ib.colour = 8'h33;
    ib.req_valid = 1'b1;
    tick();
    ib.x0 = 8'h44; ib.y0 = 8'h55; ib.colour = 8'h66;
    model(1'b0, 'h11, 'h22, 0, 0, 'h33, q, rej);
    foreach (q[i]) begin
      chk($sformatf("b2b_first%0d", i), ib.cmd, q[i]);
      tick();
    end
    chk("b2b_idle_valid", 8'(ib.cmd_valid), 8'd0);
    chk("b2b_idle_cmd", ib.cmd, 8'hA5);
    chk("b2b_idle_ready", 8'(ib.req_ready), 8'd1);
    tick();
    ib.req_valid = 1'b0;
    model(1'b0, 'h44, 'h55, 0, 0, 'h66, q, rej);
    foreach (q[i]) begin
      chk($sformatf("b2b_second%0d", i), ib.cmd, q[i]);
      chk("b2b_valid", 8'(ib.cmd_valid), 8'd1);
      tick();
    end
    chk("b2b_ready_end", 8'(ib.req_ready), 8'd1);

    // Reset during the seventh byte of a line
    model(1'b1, 1, 2, 9, 6, 8, q, rej);
    drive_a(1'b1, 1, 2, 9, 6, 8);
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_byte7", ia.cmd, q[6]);
    chk("pre_rst_valid", 8'(ia.cmd_valid), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 8'(ia.cmd_valid), 8'd0);
    chk("mid_rst_cmd", ia.cmd, 8'h00);
    chk("mid_rst_ready", 8'(ia.req_ready), 8'd1);
    chk("mid_rst_busy", 8'(ia.busy), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_a(1'b0, 200, 100, 0, 0, 42);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
